ifetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the main control decoder.
- Owns the PC and fetches instructions from instruction memory over a req/ack handshake.
- Presents the instruction with opcode/func slices to the decoder.
- Computes the next PC from the decoder's PC_sel/IsJump outputs and the datapath's branch condition when the datapath retires the current instruction.

---
 rtl/ifetch_unit_pkg.sv | 17 +
 rtl/ifetch_unit_npc_calc.sv | 26 ++
 rtl/ifetch_unit.sv | 82 ++++++++
 tb/tb_ifetch_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_unit_pkg.sv
// ifetch_unit_pkg: shared fetch/decoder encodings (PC_SEL, IsJump, fetch FSM states)
package ifetch_unit_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;
  localparam logic [1:0] PC_SEL_SEQ = 2'b00;
  localparam logic [1:0] PC_SEL_BR  = 2'b01;
  localparam logic [1:0] JUMP_NONE  = 2'b00;
  localparam logic [1:0] JUMP_J     = 2'b01;
  localparam logic [1:0] JUMP_JR    = 2'b10;
  localparam logic [31:0] PC_STEP   = 32'd4;
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction
endpackage

// File: rtl/ifetch_unit_npc_calc.sv
// npc_calc: next-PC selection; jumps outrank branches, unknown codes fall back to sequential.
// IFETCH_ALIGN_CHECK_EN keeps the raw low bits so the fetch unit can flag misalignment.
module npc_calc
  import ifetch_unit_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [25:0] instr,
  input  logic [1:0]  pc_sel,
  input  logic [1:0]  is_jump,
  input  logic        branch_cond,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc
);
  logic [31:0] raw_pc;
  always_comb begin
    raw_pc = is_jump == JUMP_J  ? {pc_plus4[31:28], instr, 2'b00} :
             is_jump == JUMP_JR ? jr_target :
             (pc_sel == PC_SEL_BR && branch_cond) ? pc_plus4 + branch_offset(instr[15:0]) :
             pc_plus4;
  end
`ifdef IFETCH_ALIGN_CHECK_EN
  assign next_pc = raw_pc;
`else
  assign next_pc = raw_pc & 32'hFFFF_FFFC;
`endif
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: PC owner and req/ack instruction fetch feeding the decoder.
// IFETCH_ALIGN_CHECK_EN adds a sticky fetch_misalign flag that parks the FSM until reset.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  func,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  input  logic        retire,
  input  logic [1:0]  pc_sel,
  input  logic [1:0]  is_jump,
  input  logic        branch_cond,
  input  logic [31:0] jr_target
`ifdef IFETCH_ALIGN_CHECK_EN
  ,
  output logic        fetch_misalign
`endif
);
  fetch_state_e state, state_d;
  logic [31:0] next_pc;
  logic        misalign_hit;
  logic        parked;
  npc_calc u_npc (
    .pc_plus4    (pc_plus4),
    .instr       (instr[25:0]),
    .pc_sel      (pc_sel),
    .is_jump     (is_jump),
    .branch_cond (branch_cond),
    .jr_target   (jr_target),
    .next_pc     (next_pc)
  );
`ifdef IFETCH_ALIGN_CHECK_EN
  assign misalign_hit = |next_pc[1:0];
  assign parked       = fetch_misalign;
  always_ff @(posedge clk) begin
    if (rst)
      fetch_misalign <= 1'b0;
    else if (state == HOLD && retire && misalign_hit)
      fetch_misalign <= 1'b1;
  end
`else
  assign misalign_hit = 1'b0;
  assign parked       = 1'b0;
`endif
  always_comb begin
    state_d = state;
    state_d = state == IDLE  ? (parked ? IDLE : FETCH) :
              state == FETCH ? (imem_ack ? HOLD : FETCH) :
              state == HOLD  ? (retire ? (misalign_hit ? IDLE : FETCH) : HOLD) :
              IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
      instr <= '0;
    end else begin
      state <= state_d;
      if (state == FETCH && imem_ack)
        instr <= imem_rdata;
      if (state == HOLD && retire)
        pc <= next_pc;
    end
  end
  assign imem_req    = state == FETCH;
  assign imem_addr   = pc;
  assign instr_valid = state == HOLD;
  assign pc_plus4    = pc + PC_STEP;
  assign opcode      = instr[31:26];
  assign func        = instr[5:0];
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: random fetch/retire traffic with a queue scoreboard and a next-PC reference model.
module tb_ifetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_ack = 1'b0;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        retire = 1'b0;
  logic [1:0]  pc_sel = '0;
  logic [1:0]  is_jump = '0;
  logic        branch_cond = 1'b0;
  logic [31:0] jr_target = '0;
`ifdef IFETCH_ALIGN_CHECK_EN
  logic        fetch_misalign;
`endif

  ifetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ack    (imem_ack),
    .instr       (instr),
    .opcode      (opcode),
    .func        (func),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .instr_valid (instr_valid),
    .retire      (retire),
    .pc_sel      (pc_sel),
    .is_jump     (is_jump),
    .branch_cond (branch_cond),
    .jr_target   (jr_target)
`ifdef IFETCH_ALIGN_CHECK_EN
    ,
    .fetch_misalign (fetch_misalign)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] w;
  } ent_t;
  ent_t sb[$];
  ent_t cur;
  bit   prev_v = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [31:0] exp_pc = 32'h0000_3000;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference next-PC: straight arithmetic on the architectural rules.
  function automatic logic [31:0] model_npc(input logic [31:0] p, input logic [31:0] w,
                                            input logic [1:0] ps, input logic [1:0] ij,
                                            input logic bc, input logic [31:0] jr);
    logic [31:0] p4, n, imm;
    p4  = p + 32'd4;
    imm = w & 32'h0000_FFFF;
    if (imm >= 32'h0000_8000) imm = imm - 32'h0001_0000;
    if (ij == 2'd1)                n = (p4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 4);
    else if (ij == 2'd2)           n = jr;
    else if (ps == 2'd1 && bc)     n = p4 + imm * 4;
    else                           n = p4;
`ifndef IFETCH_ALIGN_CHECK_EN
    n = n - (n % 4);
`endif
    return n;
  endfunction

  // Monitor: each instruction presentation pops one expected entry and must hold it through HOLD.
  always @(negedge clk) begin
    if (instr_valid && !prev_v) begin
      if (sb.size() == 0) chk("sb_underflow", 32'd0, 32'd1);
      else cur = sb.pop_front();
    end
    if (instr_valid) begin
      chk("pc", pc, cur.pc);
      chk("instr", instr, cur.w);
      chk("opcode", 32'(opcode), cur.w / 32'h0400_0000);
      chk("func", 32'(func), cur.w % 64);
      chk("pc_plus4", pc_plus4, cur.pc + 32'd4);
    end
    prev_v = instr_valid;
  end

  task automatic do_step(input logic [31:0] w, input int dly, input bit rif, input int hold,
                         input logic [1:0] ps, input logic [1:0] ij, input logic bc,
                         input logic [31:0] jr);
    int n;
    n = 0;
    while (!imem_req && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", 32'(imem_req), 32'd1);
    chk("fetch_addr", imem_addr, exp_pc);
    for (int d = 0; d < dly; d++) begin
      retire = rif && d == 0;
      @(negedge clk);
      retire = 1'b0;
      chk("req_hold", {30'd0, imem_req, instr_valid}, 32'd2);
      chk("addr_hold", imem_addr, exp_pc);
    end
    imem_ack   = 1'b1;
    imem_rdata = w;
    sb.push_back('{exp_pc, w});
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    chk("req_drop", 32'(imem_req), 32'd0);
    for (int h = 0; h < hold; h++) @(negedge clk);
    chk("valid_hold", 32'(instr_valid), 32'd1);
    pc_sel      = ps;
    is_jump     = ij;
    branch_cond = bc;
    jr_target   = jr;
    retire      = 1'b1;
    exp_pc      = model_npc(exp_pc, w, ps, ij, bc, jr);
    @(negedge clk);
    retire      = 1'b0;
    pc_sel      = 2'($urandom);
    is_jump     = 2'($urandom);
    branch_cond = 1'($urandom);
    jr_target   = $urandom;
    chk("valid_drop", 32'(instr_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] ps, ij;
    int mode;
    repeat (3) @(negedge clk);
    chk("rst_pc", pc, 32'h0000_3000);
    chk("rst_instr", instr, 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
`ifdef IFETCH_ALIGN_CHECK_EN
    chk("rst_misalign", 32'(fetch_misalign), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'h0000_3000);
    do_step(32'h3408_0001, 0, 0, 0, 2'b00, 2'b00, 1'b0, 32'd0);
    chk("seq_next", imem_addr, 32'h0000_3004);
    do_step($urandom, 0, 0, 0, 2'b00, 2'b10, 1'b0, 32'h0000_3010);
    do_step(32'h1000_FFFE, 0, 0, 1, 2'b01, 2'b00, 1'b1, 32'd0);
    chk("br_taken", imem_addr, 32'h0000_300C);
    do_step($urandom, 0, 0, 0, 2'b00, 2'b10, 1'b0, 32'h0000_3010);
    do_step(32'h1000_FFFE, 0, 0, 0, 2'b01, 2'b00, 1'b0, 32'd0);
    chk("br_not_taken", imem_addr, 32'h0000_3014);
    do_step($urandom, 0, 0, 0, 2'b00, 2'b10, 1'b0, 32'h0000_3020);
    do_step(32'h0800_0C10, 0, 0, 0, 2'b00, 2'b01, 1'b0, 32'd0);
    chk("jump_j", imem_addr, 32'h0000_3040);
    do_step($urandom, 0, 0, 0, 2'b01, 2'b10, 1'b1, 32'h0000_4000);
    chk("jump_jr_prio", imem_addr, 32'h0000_4000);
    do_step($urandom, 3, 1, 2, 2'b00, 2'b00, 1'b0, 32'd0);
    chk("wait_state_next", imem_addr, 32'h0000_4004);
    do_step($urandom, 1, 0, 0, 2'b00, 2'b10, 1'b0, 32'hFFFF_FFFC);
    do_step($urandom, 0, 0, 0, 2'b00, 2'b00, 1'b0, 32'd0);
    chk("wrap", imem_addr, 32'h0000_0000);
    for (int i = 0; i < 60; i++) begin
      mode = $urandom_range(0, 4);
      ps = mode == 1 ? 2'b01 : mode == 4 ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      ij = mode == 2 ? 2'b01 : mode == 3 ? 2'b10 : mode == 4 ? 2'b11 : 2'b00;
      do_step($urandom, $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 2),
              ps, ij, 1'($urandom), $urandom & 32'hFFFF_FFFC);
    end
    do_step($urandom, 0, 0, 0, 2'b00, 2'b10, 1'b0, 32'h0000_4002);
`ifdef IFETCH_ALIGN_CHECK_EN
    chk("misalign_set", 32'(fetch_misalign), 32'd1);
    repeat (3) begin
      @(negedge clk);
      chk("misalign_park", 32'(imem_req), 32'd0);
    end
`else
    chk("align_force", imem_addr, 32'h0000_4000);
    do_step($urandom, 0, 0, 0, 2'b00, 2'b00, 1'b0, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_pc = 32'h0000_3000;
    @(negedge clk);
    chk("restart_req", 32'(imem_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_fetch_req", 32'(imem_req), 32'd0);
    chk("rst_fetch_pc", pc, 32'h0000_3000);
`ifdef IFETCH_ALIGN_CHECK_EN
    chk("rst_fetch_misalign", 32'(fetch_misalign), 32'd0);
`endif
    rst        = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("late_ack_req", 32'(imem_req), 32'd1);
    chk("late_ack_addr", imem_addr, 32'h0000_3000);
    chk("late_ack_valid", 32'(instr_valid), 32'd0);
    chk("late_ack_instr", instr, 32'd0);
    do_step(32'h3408_0001, 0, 0, 0, 2'b00, 2'b00, 1'b0, 32'd0);
    chk("restart_next", imem_addr, 32'h0000_3004);
    @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
